// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - instruction memory port owner: boot-loader writes, PC sequencing and fetch to decode
module instr_fetch_ctrl #(
    parameter int                ADDR_W     = 14,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              halt,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              load_valid,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_FETCH = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              instr_valid_q, instr_valid_d;
    logic              stall_eff;

    // A stall only holds once an instruction is on display; the first fetch after start always issues.
    assign stall_eff = stall & instr_valid_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    state_d = ST_LOAD;
                end else if (start) begin
                    state_d       = ST_FETCH;
                    pc_d          = START_ADDR;
                    instr_valid_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (!load_valid) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (halt) begin
                    state_d       = ST_IDLE;
                    instr_valid_d = 1'b0;
                end else if (redirect_valid) begin
                    instr_pc_d    = redirect_addr;
                    pc_d          = redirect_addr + ADDR_W'(1);
                    instr_valid_d = 1'b1;
                end else if (!stall_eff) begin
                    instr_pc_d    = pc_q;
                    pc_d          = pc_q + ADDR_W'(1);
                    instr_valid_d = 1'b1;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                instr_valid_d = 1'b0;
            end
        endcase
    end

    // Address mux: the word re-read during a stall keeps mem_rdata, and so instr, stable.
    always_comb begin
        mem_addr   = '0;
        mem_we     = 1'b0;
        load_ready = 1'b0;
        case (state_q)
            ST_LOAD: begin
                load_ready = 1'b1;
                mem_addr   = load_addr;
                mem_we     = load_valid;
            end
            ST_FETCH: begin
                if (halt) begin
                    mem_addr = pc_q;
                end else if (redirect_valid) begin
                    mem_addr = redirect_addr;
                end else if (stall_eff) begin
                    mem_addr = instr_pc_q;
                end else begin
                    mem_addr = pc_q;
                end
            end
            default: begin
                mem_addr = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= START_ADDR;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign mem_wdata   = load_data;
    assign instr       = mem_rdata;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb/tb_instr_fetch_ctrl.sv - directed bench for instr_fetch_ctrl with a 1-cycle-latency memory model
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        halt;
    logic        stall;
    logic        redirect_valid;
    logic [13:0] redirect_addr;
    logic        load_valid;
    logic [13:0] load_addr;
    logic [31:0] load_data;
    logic        load_ready;
    logic [13:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [13:0] instr_pc;
    logic        instr_valid;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:16383];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    instr_fetch_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .halt           (halt),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .load_valid     (load_valid),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .load_ready     (load_ready),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .busy           (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        reset_n = 1'b0; start = 1'b0; halt = 1'b0; stall = 1'b0;
        redirect_valid = 1'b0; redirect_addr = '0;
        load_valid = 1'b0; load_addr = '0; load_data = '0;
        tick(); tick();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_load_ready", 32'(load_ready), 32'd0);
        check_eq("rst_we", 32'(mem_we), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_pc", 32'(instr_pc), 32'd0);
        reset_n = 1'b1;
        tick();

        // Load words 0..9 = 0xA+i, then 16383
        load_valid = 1'b1; load_addr = 14'd0; load_data = 32'hA;
        settle();
        check_eq("ld_idle_ready", 32'(load_ready), 32'd0);
        check_eq("ld_idle_we", 32'(mem_we), 32'd0);
        tick();
        for (int i = 0; i < 11; i++) begin
            load_addr = (i == 10) ? 14'd16383 : 14'(i);
            load_data = (i == 10) ? 32'h1234_5678 : 32'hA + 32'(i);
            settle();
            if (i < 3) begin
                check_eq($sformatf("ld_ready%0d", i), 32'(load_ready), 32'd1);
                check_eq($sformatf("ld_we%0d", i), 32'(mem_we), 32'd1);
                check_eq($sformatf("ld_addr%0d", i), 32'(mem_addr), 32'(i));
                check_eq($sformatf("ld_wdata%0d", i), mem_wdata, 32'hA + 32'(i));
            end
            tick();
        end
        load_valid = 1'b0;
        settle();
        check_eq("ld_end_we", 32'(mem_we), 32'd0);
        check_eq("ld_end_busy", 32'(busy), 32'd1);
        tick();
        check_eq("ld_idle_busy", 32'(busy), 32'd0);
        check_eq("ld_idle_ready2", 32'(load_ready), 32'd0);

        // Start and sequential fetch
        start = 1'b1;
        tick();
        start = 1'b0;
        settle();
        check_eq("f_first_valid", 32'(instr_valid), 32'd0);
        check_eq("f_first_addr", 32'(mem_addr), 32'd0);
        check_eq("f_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 6; k++) begin
            tick();
            check_eq($sformatf("f_pc%0d", k), 32'(instr_pc), 32'(k));
            check_eq($sformatf("f_instr%0d", k), instr, 32'hA + 32'(k));
            check_eq($sformatf("f_valid%0d", k), 32'(instr_valid), 32'd1);
            if (k < 3) check_eq($sformatf("f_addr%0d", k), 32'(mem_addr), 32'(k + 1));
        end

        // Stall 3 cycles at instr_pc=5
        stall = 1'b1;
        settle();
        check_eq("st_addr", 32'(mem_addr), 32'd5);
        for (int s = 0; s < 2; s++) begin
            tick();
            check_eq($sformatf("st_pc%0d", s), 32'(instr_pc), 32'd5);
            check_eq($sformatf("st_instr%0d", s), instr, 32'hF);
            check_eq($sformatf("st_valid%0d", s), 32'(instr_valid), 32'd1);
            check_eq($sformatf("st_addr%0d", s), 32'(mem_addr), 32'd5);
        end
        tick();
        stall = 1'b0;
        settle();
        check_eq("st_resume_addr", 32'(mem_addr), 32'd6);
        tick();
        check_eq("st_resume_pc", 32'(instr_pc), 32'd6);
        check_eq("st_resume_instr", instr, 32'h10);

        // Redirect with stall to 16383, wrap to 0
        stall = 1'b1; redirect_valid = 1'b1; redirect_addr = 14'd16383;
        settle();
        check_eq("rd_addr", 32'(mem_addr), 32'd16383);
        tick();
        stall = 1'b0; redirect_valid = 1'b0;
        settle();
        check_eq("rd_pc", 32'(instr_pc), 32'd16383);
        check_eq("rd_instr", instr, 32'h1234_5678);
        check_eq("rd_wrap_addr", 32'(mem_addr), 32'd0);
        tick();
        check_eq("rd_pc_wrap0", 32'(instr_pc), 32'd0);
        check_eq("rd_instr_wrap0", instr, 32'hA);
        tick();
        check_eq("rd_pc_wrap1", 32'(instr_pc), 32'd1);
        check_eq("rd_instr_wrap1", instr, 32'hB);

        // Loader ignored while fetching
        load_valid = 1'b1; load_addr = 14'd3; load_data = 32'hBAD;
        settle();
        check_eq("fl_ready", 32'(load_ready), 32'd0);
        check_eq("fl_we", 32'(mem_we), 32'd0);
        tick();
        load_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check_eq("fl_pc7", 32'(instr_pc), 32'd7);
        check_eq("fl_mem3", instr, 32'h11);

        // Reset mid-fetch
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_eq("mr_busy", 32'(busy), 32'd0);
        check_eq("mr_valid", 32'(instr_valid), 32'd0);
        check_eq("mr_ready", 32'(load_ready), 32'd0);
        check_eq("mr_we", 32'(mem_we), 32'd0);
        check_eq("mr_addr", 32'(mem_addr), 32'd0);
        check_eq("mr_pc", 32'(instr_pc), 32'd0);

        // start and load_valid together: load wins
        start = 1'b1; load_valid = 1'b1; load_addr = 14'd20; load_data = 32'h55;
        tick();
        start = 1'b0;
        settle();
        check_eq("sl_ready", 32'(load_ready), 32'd1);
        check_eq("sl_valid", 32'(instr_valid), 32'd0);
        check_eq("sl_addr", 32'(mem_addr), 32'd20);
        tick();
        load_valid = 1'b0;
        tick();
        check_eq("sl_idle", 32'(busy), 32'd0);
        tick();
        check_eq("sl_nofetch", 32'(busy), 32'd0);

        // Halt from FETCH
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_eq("h_valid_before", 32'(instr_valid), 32'd1);
        check_eq("h_pc_before", 32'(instr_pc), 32'd1);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check_eq("h_busy", 32'(busy), 32'd0);
        check_eq("h_valid", 32'(instr_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
